// File: rtl/fp_add_normalize_round.sv
// Post-add normalize / round-to-nearest-even / pack stage for binary32 addition.
// Optional FP_NORM_LZC_EN: single-cycle leading-zero normalize instead of one bit per cycle.
module fp_add_normalize_round #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sign,
    input  logic [7:0]      in_exp,
    input  logic [27:0]     in_sum,
    input  logic            in_nan,
    input  logic            in_inf,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            overflow,
    output logic            underflow,
    output logic            exception
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_sign;
    logic [9:0]        r_exp;
    logic [27:0]       r_m;
    logic [XLEN-1:0]   r_result;
    logic              r_ovf;
    logic              r_unf;
    logic              r_exc;

    logic              w_accept;
    logic [9:0]        w_e0;
    logic [27:0]       w_nm;
    logic [9:0]        w_ne;
    logic              w_norm_done;
    logic [24:0]       w_t;
    logic [9:0]        w_efin;
    logic [9:0]        w_efld;
    logic              w_ovf;
    logic              w_unf;
    logic [XLEN-1:0]   w_res;

    function automatic logic [24:0] rne_round(input logic [27:0] m);
        logic inc;
        inc = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[26:3]} + {24'd0, inc};
    endfunction

    assign w_accept = in_valid && in_ready;
    assign w_e0     = (in_exp == 8'd0) ? 10'd1 : {2'b00, in_exp};

`ifdef FP_NORM_LZC_EN
    logic [4:0] w_lz;
    logic [9:0] w_sh;

    always_comb begin
        w_lz = 5'd26;
        for (int i = 0; i <= 26; i++) begin
            if (r_m[i]) w_lz = 5'(26 - i);
        end
    end

    // Shift is clamped so the exponent never drops below 1 (denormal result).
    assign w_sh        = ({5'd0, w_lz} > (r_exp - 10'd1)) ? (r_exp - 10'd1) : {5'd0, w_lz};
    assign w_nm        = r_m << w_sh;
    assign w_ne        = r_exp - w_sh;
    assign w_norm_done = 1'b1;
`else
    assign w_nm        = (r_exp > 10'd1) ? (r_m << 1) : r_m;
    assign w_ne        = (r_exp > 10'd1) ? (r_exp - 10'd1) : r_exp;
    assign w_norm_done = w_nm[26] || (w_ne == 10'd1);
`endif

    // A denormal (hidden bit clear) has exponent field 0 unless rounding carries into bit 23.
    always_comb begin
        w_t    = rne_round(r_m);
        w_efin = r_exp + {9'd0, w_t[24]};
        w_efld = r_m[26] ? w_efin : {9'd0, w_t[23]};
        w_ovf  = (w_efld >= 10'd255);
        w_unf  = (w_efld == 10'd0) && (r_m[2] | r_m[1] | r_m[0]);
        w_res  = w_ovf ? {r_sign, 8'hFF, 23'd0} : {r_sign, w_efld[7:0], w_t[22:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_nan || in_inf || (in_sum == 28'd0)) w_next = DONE;
                    else if (in_sum[27] || in_sum[26])         w_next = ROUND;
                    else                                       w_next = NORM;
                end
            end
            NORM:    if (w_norm_done) w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE) && !rst;
        out_valid = (r_state == DONE);
        result    = r_result;
        overflow  = r_ovf;
        underflow = r_unf;
        exception = r_exc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_exc    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign <= in_sign;
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b0;
                        r_exc  <= 1'b0;
                        r_m    <= in_sum;
                        r_exp  <= w_e0;
                        if (in_nan) begin
                            r_result <= 32'h7FC00000;
                            r_exc    <= 1'b1;
                        end else if (in_inf) begin
                            r_result <= {in_sign, 8'hFF, 23'd0};
                        end else if (in_sum == 28'd0) begin
                            r_result <= '0;
                        end else if (in_sum[27]) begin
                            r_m   <= {1'b0, in_sum[27:2], in_sum[1] | in_sum[0]};
                            r_exp <= w_e0 + 10'd1;
                        end
                    end
                end
                NORM: begin
                    r_m   <= w_nm;
                    r_exp <= w_ne;
                end
                ROUND: begin
                    r_result <= w_res;
                    r_ovf    <= w_ovf;
                    r_unf    <= w_unf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_normalize_round.sv
// Directed-vector bench for fp_add_normalize_round: table of raw sums with
// hand-computed binary32 results, flags and latency, plus handshake/reset sequences.
module tb_fp_add_normalize_round;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_sum;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        exception;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] sum;
        logic        nan;
        logic        inf;
        logic [31:0] res;
        logic [2:0]  flags;   // {overflow, underflow, exception}
        int          lat;
        int          lat_lzc;
    } vec_t;

    vec_t vt[20];

    fp_add_normalize_round #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_sum    (in_sum),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .exception (exception)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit early, input string nm);
        int lat;
        int exp_lat;
        @(negedge clk);
        in_sign   = v.sign;
        in_exp    = v.exp;
        in_sum    = v.sum;
        in_nan    = v.nan;
        in_inf    = v.inf;
        in_valid  = 1'b1;
        out_ready = early;
        check({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
`ifdef FP_NORM_LZC_EN
        exp_lat = v.lat_lzc;
`else
        exp_lat = v.lat;
`endif
        check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        check({nm, "_result"}, result, v.res);
        check({nm, "_flags"}, {29'd0, overflow, underflow, exception}, {29'd0, v.flags});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({nm, "_consumed"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        //        sign  exp    sum          nan   inf   result        flags   lat lzc
        vt[0]  = '{1'b0, 8'd127, 28'h4000000, 1'b0, 1'b0, 32'h3F800000, 3'b000, 2, 2};
        vt[1]  = '{1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0, 32'h40000000, 3'b000, 2, 2};
        vt[2]  = '{1'b0, 8'd130, 28'h0800000, 1'b0, 1'b0, 32'h3F800000, 3'b000, 5, 3};
        vt[3]  = '{1'b0, 8'd127, 28'h400000C, 1'b0, 1'b0, 32'h3F800002, 3'b000, 2, 2};
        vt[4]  = '{1'b0, 8'd127, 28'h4000004, 1'b0, 1'b0, 32'h3F800000, 3'b000, 2, 2};
        vt[5]  = '{1'b0, 8'd254, 28'h8000000, 1'b0, 1'b0, 32'h7F800000, 3'b100, 2, 2};
        vt[6]  = '{1'b0, 8'd10,  28'h4000000, 1'b1, 1'b0, 32'h7FC00000, 3'b001, 1, 1};
        vt[7]  = '{1'b1, 8'd200, 28'h4000000, 1'b0, 1'b1, 32'hFF800000, 3'b000, 1, 1};
        vt[8]  = '{1'b1, 8'd50,  28'h0000000, 1'b0, 1'b0, 32'h00000000, 3'b000, 1, 1};
        vt[9]  = '{1'b0, 8'd1,   28'h2000000, 1'b0, 1'b0, 32'h00400000, 3'b000, 3, 3};
        vt[10] = '{1'b0, 8'd0,   28'h2000001, 1'b0, 1'b0, 32'h00400000, 3'b010, 3, 3};
        vt[11] = '{1'b0, 8'd1,   28'h3FFFFFC, 1'b0, 1'b0, 32'h00800000, 3'b000, 3, 3};
        vt[12] = '{1'b0, 8'd3,   28'h0800000, 1'b0, 1'b0, 32'h00400000, 3'b000, 4, 3};
        vt[13] = '{1'b0, 8'd127, 28'h8000003, 1'b0, 1'b0, 32'h40000000, 3'b000, 2, 2};
        vt[14] = '{1'b0, 8'd127, 28'h7FFFFFC, 1'b0, 1'b0, 32'h40000000, 3'b000, 2, 2};
        vt[15] = '{1'b0, 8'd254, 28'h7FFFFFC, 1'b0, 1'b0, 32'h7F800000, 3'b100, 2, 2};
        vt[16] = '{1'b1, 8'd5,   28'h4000000, 1'b1, 1'b1, 32'h7FC00000, 3'b001, 1, 1};
        vt[17] = '{1'b1, 8'd127, 28'h4000000, 1'b0, 1'b0, 32'hBF800000, 3'b000, 2, 2};
        vt[18] = '{1'b0, 8'd127, 28'h0000008, 1'b0, 1'b0, 32'h34000000, 3'b000, 25, 3};
        vt[19] = '{1'b0, 8'd127, 28'h0000001, 1'b0, 1'b0, 32'h32800000, 3'b000, 28, 3};

        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_sum = '0;
        in_nan = 1'b0; in_inf = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {29'd0, overflow, underflow, exception}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 20; i++) run_vec(vt[i], 1'b0, $sformatf("vec%0d", i));

        // out_ready high before the result exists
        run_vec(vt[2], 1'b1, "early_ready");

        // NaN held while the consumer stalls; a second offer must be ignored
        @(negedge clk);
        in_nan = 1'b1; in_inf = 1'b0; in_sign = 1'b0; in_sum = 28'h4000000; in_exp = 8'd127;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_nan = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_valid_ready", i), {30'd0, out_valid, in_ready}, 32'b10);
            check($sformatf("hold%0d_result", i), result, 32'h7FC00000);
            check($sformatf("hold%0d_flags", i), {29'd0, overflow, underflow, exception}, 32'b001);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_consumed", {30'd0, out_valid, in_ready}, 32'b01);

        // reset while normalizing drops the transaction
        @(negedge clk);
        in_sign = 1'b0; in_exp = 8'd130; in_sum = 28'h0800000; in_nan = 1'b0; in_inf = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid_ready", {30'd0, out_valid, in_ready}, 32'b00);
        check("midrst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_idle", {30'd0, out_valid, in_ready}, 32'b01);
        run_vec(vt[2], 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
